// File: rtl/allophone_feeder_pkg.sv
// Shared definitions for the allophone feeder: code width, default sizing
// and the load-sequencer state encoding.
package allophone_feeder_pkg;

    localparam int ALLO_W           = 6;
    localparam int FEED_DEPTH       = 16;
    localparam int FEED_LDQ_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        FEED_IDLE     = 2'd0,
        FEED_STROBE   = 2'd1,
        FEED_WAIT_LOW = 2'd2
    } feed_state_t;

endpackage

// File: rtl/allophone_sync_fifo.sv
// DEPTH x 6 synchronous FIFO with explicit occupancy counter and flush.
// Full/empty derive from the level counter; pointers wrap naturally.
module allophone_sync_fifo
    import allophone_feeder_pkg::*;
#(
    parameter int DEPTH = FEED_DEPTH,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              rst_an,
    input  logic              i_wr,
    input  logic [ALLO_W-1:0] i_wdata,
    input  logic              i_rd,
    input  logic              i_flush,
    output logic [ALLO_W-1:0] o_rdata,
    output logic [AW:0]       o_level,
    output logic              o_full,
    output logic              o_empty
);

    logic [ALLO_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_level;
    logic              w_wr_ok;
    logic              w_rd_ok;

    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rptr];

    // Fullness is judged on the pre-pop level, so a pop never makes room.
    assign w_wr_ok = i_wr && !o_full && !i_flush;
    assign w_rd_ok = i_rd && !o_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_an || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_wr_ok, w_rd_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/allophone_feeder.sv
// Host allophone buffer and ldq-paced load sequencer feeding Speech256.
// One code per ldq window: after each strobe, ldq must fall before the next load.
module allophone_feeder
    import allophone_feeder_pkg::*;
#(
    parameter int DEPTH       = FEED_DEPTH,
    parameter int AW          = 4,
    parameter int LDQ_TIMEOUT = FEED_LDQ_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_an,
    input  logic [ALLO_W-1:0] host_data,
    input  logic              host_wr,
    input  logic              flush,
    input  logic              err_clr,
    input  logic              ldq,
    output logic [ALLO_W-1:0] data_out,
    output logic              data_stb,
    output logic              host_full,
    output logic [AW:0]       host_level,
    output logic              active,
    output logic              overflow,
    output logic              timeout_err
);

    localparam int CW = (LDQ_TIMEOUT > 2) ? $clog2(LDQ_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LDQ_TIMEOUT - 1);

    feed_state_t       r_state;
    feed_state_t       w_next;
    logic [CW-1:0]     r_cnt;
    logic [ALLO_W-1:0] r_data;
    logic              r_ovf;
    logic              r_to;
    logic [ALLO_W-1:0] w_head;
    logic [AW:0]       w_level;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_cnt_last;
    logic              w_to_set;
    logic              w_ovf_set;

    allophone_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst_an  (rst_an),
        .i_wr    (host_wr),
        .i_wdata (host_data),
        .i_rd    (w_pop),
        .i_flush (flush),
        .o_rdata (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pop      = (r_state == FEED_IDLE) && ldq && !w_empty;
    assign w_cnt_last = (r_cnt == CNT_LAST);
    // A falling ldq on the last count still counts as a clean handshake.
    assign w_to_set   = (r_state == FEED_WAIT_LOW) && ldq && w_cnt_last;
    assign w_ovf_set  = host_wr && w_full && !flush;

    always_ff @(posedge clk) begin
        if (!rst_an) begin
            r_state <= FEED_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            FEED_IDLE: begin
                if (w_pop) begin
                    w_next = FEED_STROBE;
                end
            end
            FEED_STROBE: begin
                w_next = FEED_WAIT_LOW;
            end
            FEED_WAIT_LOW: begin
                if (!ldq || w_cnt_last) begin
                    w_next = FEED_IDLE;
                end
            end
            default: begin
                w_next = FEED_IDLE;
            end
        endcase
    end

    always_comb begin
        data_stb = (r_state == FEED_STROBE);
        active   = !w_empty || (r_state != FEED_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_an) begin
            r_cnt  <= '0;
            r_data <= '0;
            r_ovf  <= 1'b0;
            r_to   <= 1'b0;
        end else begin
            if (r_state == FEED_STROBE) begin
                r_cnt <= '0;
            end else if (r_state == FEED_WAIT_LOW) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_pop) begin
                r_data <= w_head;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (err_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_to_set) begin
                r_to <= 1'b1;
            end else if (err_clr) begin
                r_to <= 1'b0;
            end
        end
    end

    assign data_out    = r_data;
    assign host_full   = w_full;
    assign host_level  = w_level;
    assign overflow    = r_ovf;
    assign timeout_err = r_to;

endmodule
